// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite mover
// Purpose: FSM state encoding, named colours and screen bounds shared by
//          sprite_mover and its sub-module.
// Ports:   none (package).
package sprite_pkg;

  // Control states: DRAW paints the sprite, WAIT idles for a frame tick,
  // ERASE paints the old sprite in the background colour, MOVE commits pos_x.
  typedef enum logic [1:0] {
    S_DRAW  = 2'd0,
    S_WAIT  = 2'd1,
    S_ERASE = 2'd2,
    S_MOVE  = 2'd3
  } state_e;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] GREEN = 3'b010;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

endpackage

// File: rtl/sprite_mover_frame_divider.sv
// rtl/sprite_mover_frame_divider.sv - frame tick divider for the sprite mover
// Purpose: counts 0..TICK_DIV-1 and wraps; tick is a registered one-cycle
//          pulse that is high exactly while the count equals TICK_DIV-1.
// Ports:   clk    - system clock
//          resetn - asynchronous active-low reset
//          tick   - one-cycle frame pulse
module frame_divider #(
  parameter int unsigned TICK_DIV = 833334
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;

  assign cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);

  // The pulse is registered from the next count so it lines up with the
  // cycle in which cnt_q itself holds the last value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - moves a solid rectangle left/right once per frame tick
// Purpose: on each requested move, erases the sprite, updates its origin and
//          redraws it, streaming one pixel per clock to a vga_adapter.
// Ports:   clk    - system clock
//          resetn - asynchronous active-low reset
//          left   - move-left request, sampled when a tick is serviced
//          right  - move-right request, sampled when a tick is serviced
//          x, y   - registered pixel coordinate
//          colour - registered pixel colour
//          plot   - registered pixel write strobe
//          busy   - registered, high while not idling in WAIT
//          tick   - one-cycle frame pulse
module sprite_mover
  import sprite_pkg::*;
#(
  parameter int unsigned      X_W      = 8,
  parameter int unsigned      Y_W      = 7,
  parameter int unsigned      COL_W    = 3,
  parameter int unsigned      SPR_W    = 8,
  parameter int unsigned      SPR_H    = 2,
  parameter int unsigned      X_MIN    = 0,
  parameter int unsigned      X_MAX    = 152,
  parameter int unsigned      X_START  = 76,
  parameter int unsigned      Y_POS    = 110,
  parameter int unsigned      STEP     = 1,
  parameter logic [COL_W-1:0] FG       = COL_W'(GREEN),
  parameter logic [COL_W-1:0] BG       = COL_W'(BLACK),
  parameter int unsigned      TICK_DIV = 833334
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             left,
  input  logic             right,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [COL_W-1:0] colour,
  output logic             plot,
  output logic             busy,
  output logic             tick
);

  localparam int unsigned CXW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned CYW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int unsigned XE  = X_W + 1;

  state_e           state_q, state_d;
  logic [X_W-1:0]   pos_x_q, pos_x_d;
  logic [X_W-1:0]   nxt_x_q, nxt_x_d;
  logic [CXW-1:0]   cx_q, cx_d;
  logic [CYW-1:0]   cy_q, cy_d;
  logic             pending_q, pending_d;

  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [COL_W-1:0] colour_q, colour_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;

  logic             tick_w;
  logic             cx_last;
  logic             scan_last;
  logic [XE-1:0]    pos_ext;
  logic [XE-1:0]    left_ext;
  logic [XE-1:0]    right_ext;
  logic [X_W-1:0]   target;
  logic             move_ok;

  frame_divider #(
    .TICK_DIV(TICK_DIV)
  ) u_frame_divider (
    .clk   (clk),
    .resetn(resetn),
    .tick  (tick_w)
  );

  assign cx_last   = (cx_q == CXW'(SPR_W - 1));
  assign scan_last = cx_last && (cy_q == CYW'(SPR_H - 1));

  // Clamp in one extra bit so neither direction can wrap past the bounds.
  assign pos_ext   = {1'b0, pos_x_q};
  assign left_ext  = (pos_ext < XE'(X_MIN + STEP)) ? XE'(X_MIN) : pos_ext - XE'(STEP);
  assign right_ext = ((pos_ext + XE'(STEP)) > XE'(X_MAX)) ? XE'(X_MAX) : pos_ext + XE'(STEP);
  assign target    = left ? left_ext[X_W-1:0] : right_ext[X_W-1:0];
  assign move_ok   = (left ^ right) && (target != pos_x_q);

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_DRAW;
      pos_x_q   <= X_W'(X_START);
      nxt_x_q   <= X_W'(X_START);
      cx_q      <= '0;
      cy_q      <= '0;
      pending_q <= 1'b0;
      x_q       <= X_W'(X_START);
      y_q       <= Y_W'(Y_POS);
      colour_q  <= BG;
      plot_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      nxt_x_q   <= nxt_x_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      pending_q <= pending_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
      plot_q    <= plot_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    nxt_x_d   = nxt_x_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    pending_d = pending_q;

    // A tick outside WAIT is remembered once; repeats collapse into it.
    if (tick_w && (state_q != S_WAIT)) begin
      pending_d = 1'b1;
    end

    // Scan counters step in both painting states and wrap to 0 at the end,
    // so every scan starts from the top-left corner.
    if ((state_q == S_DRAW) || (state_q == S_ERASE)) begin
      if (cx_last) begin
        cx_d = '0;
        cy_d = scan_last ? '0 : cy_q + CYW'(1);
      end else begin
        cx_d = cx_q + CXW'(1);
      end
    end

    case (state_q)
      S_DRAW: begin
        if (scan_last) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tick_w || pending_q) begin
          pending_d = 1'b0;
          if (move_ok) begin
            nxt_x_d = target;
            state_d = S_ERASE;
          end
        end
      end
      S_ERASE: begin
        if (scan_last) state_d = S_MOVE;
      end
      S_MOVE: begin
        pos_x_d = nxt_x_q;
        state_d = S_DRAW;
      end
      default: state_d = S_DRAW;
    endcase
  end

  // Output logic, registered one cycle behind the state and counters.
  always_comb begin
    plot_d   = (state_q == S_DRAW) || (state_q == S_ERASE);
    x_d      = pos_x_q + X_W'(cx_q);
    y_d      = Y_W'(Y_POS) + Y_W'(cy_q);
    colour_d = (state_q == S_DRAW) ? FG : BG;
    busy_d   = (state_q != S_WAIT);
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign tick   = tick_w;

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - self-checking bench for sprite_mover
module tb_sprite_mover;

  localparam int SW   = 4;
  localparam int SH   = 2;
  localparam int XMIN = 2;
  localparam int XMAX = 10;
  localparam int XST  = 6;
  localparam int STP  = 3;
  localparam int YP   = 110;
  localparam int FGC  = 2;
  localparam int BGC  = 0;
  localparam int NPIX = SW * SH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       resetn1 = 1'b0, left1 = 1'b0, right1 = 1'b0;
  logic [7:0] x1;
  logic [6:0] y1;
  logic [2:0] col1;
  logic       plot1, busy1, tick1;

  logic       resetn2 = 1'b0, left2 = 1'b0, right2 = 1'b0;
  logic [7:0] x2;
  logic [6:0] y2;
  logic [2:0] col2;
  logic       plot2, busy2, tick2;

  sprite_mover #(
    .SPR_W(SW), .SPR_H(SH), .X_MIN(XMIN), .X_MAX(XMAX), .X_START(XST),
    .STEP(STP), .TICK_DIV(32)
  ) dut (
    .clk(clk), .resetn(resetn1), .left(left1), .right(right1),
    .x(x1), .y(y1), .colour(col1), .plot(plot1), .busy(busy1), .tick(tick1)
  );

  sprite_mover #(
    .SPR_W(SW), .SPR_H(SH), .X_MIN(XMIN), .X_MAX(XMAX), .X_START(XST),
    .STEP(STP), .TICK_DIV(10)
  ) dut2 (
    .clk(clk), .resetn(resetn2), .left(left2), .right(right2),
    .x(x2), .y(y2), .colour(col2), .plot(plot2), .busy(busy2), .tick(tick2)
  );

  typedef struct {
    int c;
    int x;
    int y;
    int col;
  } ev_t;

  ev_t q1[$];
  ev_t q2[$];
  int  busy1_total = 0;

  always @(negedge clk) begin
    if (plot1) q1.push_back('{cyc, int'(x1), int'(y1), int'(col1)});
    if (plot2) q2.push_back('{cyc, int'(x2), int'(y2), int'(col2)});
    if (busy1) busy1_total <= busy1_total + 1;
  end

  int n_pass  = 0;
  int n_total = 0;
  int model_pos1;

  // Reference rule for one serviced tick.
  function automatic int next_pos(input int pos, input bit l, input bit r);
    if (l == r) return pos;
    if (l) return (pos < XMIN + STP) ? XMIN : pos - STP;
    return (pos + STP > XMAX) ? XMAX : pos + STP;
  endfunction

  task automatic test_reset();
    int base, r0, n;
    ev_t e;
    resetn1 = 1'b0; left1 = 1'b0; right1 = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({plot1, busy1, tick1} !== 3'b010) $display("FAIL reset_flags plot/busy/tick=%b%b%b exp 010", plot1, busy1, tick1);
    else n_pass++;
    n_total++;
    if (int'(x1) !== XST || int'(y1) !== YP || int'(col1) !== BGC)
      $display("FAIL reset_xyc got %0d,%0d,%0d exp %0d,%0d,%0d", x1, y1, col1, XST, YP, BGC);
    else n_pass++;
    base = q1.size();
    r0 = cyc;
    resetn1 = 1'b1;
    model_pos1 = XST;
    repeat (12) @(negedge clk);
    n = q1.size() - base;
    n_total++;
    if (n !== NPIX) $display("FAIL reset_draw_count got %0d exp %0d", n, NPIX);
    else n_pass++;
    for (int i = 0; i < NPIX && i < n; i++) begin
      e = q1[base + i];
      n_total++;
      if (e.c !== r0 + 1 + i || e.x !== XST + i % SW || e.y !== YP + i / SW || e.col !== FGC)
        $display("FAIL reset_draw[%0d] got c%0d x%0d y%0d col%0d exp c%0d x%0d y%0d col%0d",
                 i, e.c - r0, e.x, e.y, e.col, 1 + i, XST + i % SW, YP + i / SW, FGC);
      else n_pass++;
    end
    n_total++;
    if (busy1 !== 1'b0) $display("FAIL reset_busy_idle got %b exp 0", busy1);
    else n_pass++;
  endtask

  // Directed sequence (rnd=0) or random requests (rnd=1), one tick each.
  task automatic test_moves(input bit rnd, input int count);
    logic [1:0] dir_tab [9];
    logic [1:0] lr;
    int qb, bb, tc, newp, oldp, n, nb, ec, ex, ey, ecol;
    bit moved;
    ev_t e;
    dir_tab = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
    for (int k = 0; k < count; k++) begin
      lr = rnd ? 2'($urandom_range(0, 3)) : dir_tab[k % 9];
      left1 = lr[1]; right1 = lr[0];
      oldp  = model_pos1;
      newp  = next_pos(oldp, lr[1], lr[0]);
      moved = (newp != oldp);
      qb = q1.size();
      bb = busy1_total;
      tc = -1;
      for (int w = 0; w < 80; w++) begin
        @(negedge clk);
        if (tick1) begin
          tc = cyc;
          break;
        end
      end
      n_total++;
      if (tc < 0) begin
        $display("FAIL move_tick_timeout no tick within 80 cycles");
        continue;
      end
      n_pass++;
      repeat (22) @(negedge clk);
      n  = q1.size() - qb;
      nb = busy1_total - bb;
      n_total++;
      if (n !== (moved ? 2 * NPIX : 0))
        $display("FAIL move_count k%0d lr%b pos%0d got %0d exp %0d", k, lr, oldp, n, moved ? 2 * NPIX : 0);
      else n_pass++;
      n_total++;
      if (nb !== (moved ? 2 * NPIX + 1 : 0))
        $display("FAIL move_busy_cycles k%0d got %0d exp %0d", k, nb, moved ? 2 * NPIX + 1 : 0);
      else n_pass++;
      for (int i = 0; moved && i < n && i < 2 * NPIX; i++) begin
        e = q1[qb + i];
        if (i < NPIX) begin
          ec = tc + 2 + i; ex = oldp + i % SW; ey = YP + i / SW; ecol = BGC;
        end else begin
          ec = tc + 11 + (i - NPIX); ex = newp + (i - NPIX) % SW; ey = YP + (i - NPIX) / SW; ecol = FGC;
        end
        n_total++;
        if (e.c !== ec || e.x !== ex || e.y !== ey || e.col !== ecol)
          $display("FAIL move_pixel k%0d i%0d got c%0d x%0d y%0d col%0d exp c%0d x%0d y%0d col%0d",
                   k, i, e.c - tc, e.x, e.y, e.col, ec - tc, ex, ey, ecol);
        else n_pass++;
      end
      model_pos1 = newp;
    end
    left1 = 1'b0; right1 = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int tc, base, r0, n;
    ev_t e;
    resetn1 = 1'b0; left1 = 1'b0; right1 = 1'b1;
    repeat (2) @(negedge clk);
    resetn1 = 1'b1;
    // Two right moves: 6->9, then reset during the erase of the sprite at 9.
    for (int t = 0; t < 2; t++) begin
      tc = -1;
      for (int w = 0; w < 80; w++) begin
        @(negedge clk);
        if (tick1) begin
          tc = cyc;
          break;
        end
      end
      n_total++;
      if (tc < 0) $display("FAIL midreset_tick_timeout tick %0d", t);
      else n_pass++;
      repeat ((t == 0) ? 22 : 4) @(negedge clk);
    end
    n_total++;
    if (plot1 !== 1'b1 || int'(col1) !== BGC) $display("FAIL midreset_in_erase plot=%b col=%0d exp 1,%0d", plot1, col1, BGC);
    else n_pass++;
    #2 resetn1 = 1'b0;
    #1;
    n_total++;
    if (plot1 !== 1'b0 || int'(x1) !== XST || busy1 !== 1'b1)
      $display("FAIL midreset_async got plot=%b x=%0d busy=%b exp 0,%0d,1", plot1, x1, busy1, XST);
    else n_pass++;
    right1 = 1'b0;
    repeat (2) @(negedge clk);
    base = q1.size();
    r0 = cyc;
    resetn1 = 1'b1;
    model_pos1 = XST;
    repeat (12) @(negedge clk);
    n = q1.size() - base;
    n_total++;
    if (n !== NPIX) $display("FAIL midreset_redraw_count got %0d exp %0d", n, NPIX);
    else n_pass++;
    for (int i = 0; i < NPIX && i < n; i++) begin
      e = q1[base + i];
      n_total++;
      if (e.c !== r0 + 1 + i || e.x !== XST + i % SW || e.y !== YP + i / SW || e.col !== FGC)
        $display("FAIL midreset_redraw[%0d] got c%0d x%0d y%0d col%0d exp c%0d x%0d y%0d col%0d",
                 i, e.c - r0, e.x, e.y, e.col, 1 + i, XST + i % SW, YP + i / SW, FGC);
      else n_pass++;
    end
  endtask

  // TICK_DIV=10: ticks after edges 9,19,29,... Moves are 17 cycles long, so
  // ticks land mid-move and are serviced as soon as WAIT is reached.
  task automatic test_pending();
    // {service edge, old x, new x}
    int mv [5][3] = '{'{10, 6, 9}, '{28, 9, 10}, '{46, 10, 7}, '{70, 7, 4}, '{88, 4, 2}};
    int exp_c [$], exp_x [$], exp_y [$], exp_col [$];
    int base, r0, n;
    ev_t e;
    for (int i = 0; i < NPIX; i++) begin
      exp_c.push_back(1 + i); exp_x.push_back(XST + i % SW);
      exp_y.push_back(YP + i / SW); exp_col.push_back(FGC);
    end
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < NPIX; i++) begin
        exp_c.push_back(mv[m][0] + 1 + i); exp_x.push_back(mv[m][1] + i % SW);
        exp_y.push_back(YP + i / SW); exp_col.push_back(BGC);
      end
      for (int i = 0; i < NPIX; i++) begin
        exp_c.push_back(mv[m][0] + 10 + i); exp_x.push_back(mv[m][2] + i % SW);
        exp_y.push_back(YP + i / SW); exp_col.push_back(FGC);
      end
    end
    resetn2 = 1'b0; left2 = 1'b0; right2 = 1'b1;
    repeat (2) @(negedge clk);
    base = q2.size();
    r0 = cyc;
    resetn2 = 1'b1;
    for (int rel = 1; rel <= 130; rel++) begin
      @(negedge clk);
      // rel 64: left raised right after the pending tick was consumed with no
      // request; the move must wait for the next real tick (edge 70).
      case (rel)
        40: begin left2 = 1'b1; right2 = 1'b0; end
        50: begin left2 = 1'b0; right2 = 1'b0; end
        64: begin left2 = 1'b1; right2 = 1'b0; end
        90: begin left2 = 1'b0; right2 = 1'b0; end
        default: ;
      endcase
    end
    n = q2.size() - base;
    n_total++;
    if (n !== exp_c.size()) $display("FAIL pending_count got %0d exp %0d", n, exp_c.size());
    else n_pass++;
    for (int i = 0; i < n && i < exp_c.size(); i++) begin
      e = q2[base + i];
      n_total++;
      if (e.c - r0 !== exp_c[i] || e.x !== exp_x[i] || e.y !== exp_y[i] || e.col !== exp_col[i])
        $display("FAIL pending_pixel[%0d] got c%0d x%0d y%0d col%0d exp c%0d x%0d y%0d col%0d",
                 i, e.c - r0, e.x, e.y, e.col, exp_c[i], exp_x[i], exp_y[i], exp_col[i]);
      else n_pass++;
    end
    n_total++;
    if (busy2 !== 1'b0) $display("FAIL pending_idle_busy got %b exp 0", busy2);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_moves(1'b0, 9);
    test_moves(1'b1, 20);
    test_reset_mid_scan();
    test_pending();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
